// File: rtl/pursuit_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pursuit_job_sequencer_pkg
//   Shared types and constants for the pursuit job sequencer and the rest of
//   the pursuit chip.
//   - fp_32_t             : raw 32-bit floating-point word moved over the RAM bus
//   - *_ADDR_WIDTH        : chip-level RAM address widths (ADDR_WIDTH defaults)
//   - pursuit_job_state_t : sequencer FSM states
//   - count_width()       : width of a counter that must reach max(a, b)
// -----------------------------------------------------------------------------
package pursuit_job_sequencer_pkg;

    typedef logic [31:0] fp_32_t;

    localparam int DICT_ADDR_WIDTH   = 8;
    localparam int Y_ADDR_WIDTH      = 8;
    localparam int RESULT_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT_DONE,
        ST_FETCH,
        ST_CAPTURE,
        ST_PRESENT
    } pursuit_job_state_t;

    // Counters must be able to hold the terminal count itself, hence the +1.
    function automatic int count_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pursuit_job_sequencer_timer.sv
// -----------------------------------------------------------------------------
// pursuit_wait_timer
//   Down-counter bounding how long the sequencer waits for the processor.
//   Only built when PURSUIT_JOB_SEQUENCER_TIMEOUT_EN is defined.
//   Ports:
//     clock, resetN : clock and asynchronous active-low reset
//     load          : preload CYCLES-1 (one cycle before the wait starts)
//     clear         : force the count to zero
//     enable        : count down by one, saturating at zero
//     terminal      : count is zero; in the wait state this marks the
//                     CYCLES-th wait cycle
// -----------------------------------------------------------------------------
`ifdef PURSUIT_JOB_SEQUENCER_TIMEOUT_EN
module pursuit_wait_timer #(
    parameter int CYCLES = 1024
) (
    input  logic clock,
    input  logic resetN,
    input  logic load,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule
`endif

// File: rtl/pursuit_job_sequencer.sv
// -----------------------------------------------------------------------------
// pursuit_job_sequencer
//   Host-side initiator for one matching-pursuit job: streams LOAD_COUNT words
//   into the load RAM, pulses proc_start, waits for proc_done, then reads
//   UNLOAD_COUNT result words back and streams them to the host.
//   Optional macro PURSUIT_JOB_SEQUENCER_TIMEOUT_EN bounds the processor wait
//   to TIMEOUT_CYCLES and reports expiry on the sticky timeout flag.
//   Ports:
//     clock, resetN                      : clock, async active-low reset
//     go, busy                           : job request / job in progress
//     in_valid, in_ready, in_data        : load stream from host
//     ram_write_enable/addr/data         : load RAM write port (registered)
//     ram_read_addr, ram_read_data       : result RAM read port (1-cycle read)
//     proc_start, proc_done              : processor start/done handshake
//     out_valid, out_ready, out_data,
//     out_last                           : result stream to host
//     job_done                           : one-cycle end-of-job pulse
//     timeout                            : sticky processor-timeout flag
// -----------------------------------------------------------------------------
module pursuit_job_sequencer
    import pursuit_job_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = $bits(fp_32_t),
    parameter int ADDR_WIDTH     = DICT_ADDR_WIDTH,
    parameter int LOAD_COUNT     = 64,
    parameter int UNLOAD_COUNT   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  go,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  proc_start,
    input  logic                  proc_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  job_done,
    output logic                  timeout
);

    localparam int CNT_WIDTH = count_width(LOAD_COUNT, UNLOAD_COUNT);
    localparam logic [CNT_WIDTH-1:0] LOAD_LAST   = CNT_WIDTH'(LOAD_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOAD_LAST = CNT_WIDTH'(UNLOAD_COUNT - 1);

    pursuit_job_state_t state, state_next;

    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 go_accept;
    logic                 load_accept;
    logic                 out_handshake;
    logic                 timeout_hit;

    assign busy          = (state != ST_IDLE);
    assign in_ready      = (state == ST_LOAD);
    assign go_accept     = (state == ST_IDLE) && go;
    assign load_accept   = in_valid && in_ready;
    assign out_handshake = (state == ST_PRESENT) && out_ready;
    assign ram_read_addr = ADDR_WIDTH'(rd_cnt);

`ifdef PURSUIT_JOB_SEQUENCER_TIMEOUT_EN
    logic timer_terminal;
    logic timeout_q;

    // Preloaded in KICK so the first WAIT_DONE cycle sees TIMEOUT_CYCLES-1;
    // terminal then marks the TIMEOUT_CYCLES-th wait cycle.
    pursuit_wait_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .resetN  (resetN),
        .load    (state == ST_KICK),
        .clear   (go_accept),
        .enable  (state == ST_WAIT_DONE),
        .terminal(timer_terminal)
    );

    // A done arriving in the very last wait cycle still wins over the timeout.
    assign timeout_hit = (state == ST_WAIT_DONE) && timer_terminal && !proc_done;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            timeout_q <= 1'b0;
        end else if (go_accept) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    // NOTE: state and all other flops use non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (go) state_next = ST_LOAD;
            ST_LOAD:      if (load_accept && (wr_cnt == LOAD_LAST)) state_next = ST_KICK;
            ST_KICK:      state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (proc_done)        state_next = ST_FETCH;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_FETCH:     state_next = ST_CAPTURE;
            ST_CAPTURE:   state_next = ST_PRESENT;
            ST_PRESENT:   if (out_ready) state_next = out_last ? ST_IDLE : ST_FETCH;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Registered outputs and counters. Pulses default low each cycle; the
    // output word register holds its value through PRESENT backpressure.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            ram_write_enable <= 1'b0;
            ram_write_addr   <= '0;
            ram_write_data   <= '0;
            proc_start       <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_last         <= 1'b0;
            job_done         <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            proc_start       <= 1'b0;
            job_done         <= 1'b0;

            if (go_accept) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end

            if (load_accept) begin
                ram_write_enable <= 1'b1;
                ram_write_addr   <= ADDR_WIDTH'(wr_cnt);
                ram_write_data   <= in_data;
                wr_cnt           <= wr_cnt + 1'b1;
            end

            // Registered from KICK so the final load write (issued the cycle
            // after the last acceptance) commits before the processor starts.
            if (state == ST_KICK) begin
                proc_start <= 1'b1;
            end

            if (timeout_hit) begin
                job_done <= 1'b1;
            end

            if (state == ST_CAPTURE) begin
                out_data  <= ram_read_data;
                out_valid <= 1'b1;
                out_last  <= (rd_cnt == UNLOAD_LAST);
            end

            if (out_handshake) begin
                out_valid <= 1'b0;
                rd_cnt    <= rd_cnt + 1'b1;
                if (out_last) begin
                    job_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pursuit_job_sequencer.sv
module tb_pursuit_job_sequencer;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LC = 4;
    localparam int UC = 2;
    localparam int TC = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } out_exp_t;

    logic          clock = 1'b0;
    logic          resetN = 1'b1;
    logic          go = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          ram_write_enable;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_read_data = '0;
    logic          proc_start;
    logic          proc_done;
    logic          proc_done_model = 1'b0;
    logic          proc_done_force = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          job_done;
    logic          timeout;

    logic [DW-1:0] result_mem [0:255];
    wr_exp_t       exp_wr [$];
    out_exp_t      exp_out [$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  proc_start_count = 0;
    int  done_delay = 5;
    bit  suppress_done = 1'b0;
    bit  done_given = 1'b0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    assign proc_done = proc_done_model | proc_done_force;

    pursuit_job_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .LOAD_COUNT    (LC),
        .UNLOAD_COUNT  (UC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .go              (go),
        .busy            (busy),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .ram_write_enable(ram_write_enable),
        .ram_write_addr  (ram_write_addr),
        .ram_write_data  (ram_write_data),
        .ram_read_addr   (ram_read_addr),
        .ram_read_data   (ram_read_data),
        .proc_start      (proc_start),
        .proc_done       (proc_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .job_done        (job_done),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Result RAM: registered read, one cycle latency.
    always @(posedge clock) ram_read_data <= result_mem[ram_read_addr];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Processor model: answers each proc_start with a one-cycle proc_done.
    initial begin
        forever begin
            @(negedge clock);
            if (resetN && proc_start && !suppress_done) begin
                repeat (done_delay) @(posedge clock);
                #1 proc_done_model = 1'b1;
                done_given = 1'b1;
                @(posedge clock);
                #1 proc_done_model = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (resetN && proc_start) begin
            proc_start_count++;
            start_cyc = cyc;
        end
    end

    // Write monitor.
    always @(negedge clock) begin
        if (resetN && ram_write_enable) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: addr 0x%0h data 0x%0h, expected no write", ram_write_addr, ram_write_data);
            end else begin
                wr_exp_t e;
                e = exp_wr.pop_front();
                check("write_addr", ram_write_addr, e.addr);
                check("write_data", ram_write_data, e.data);
            end
        end
    end

    // Output monitor: stability under backpressure and in-order words.
    always @(negedge clock) begin
        if (resetN) begin
            if (prev_stall) begin
                check("out_hold_valid", out_valid, 1'b1);
                check("out_hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: data 0x%0h, expected no word", out_data);
                end else begin
                    out_exp_t e;
                    e = exp_out.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    check("out_after_done", done_given, 1'b1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_quiet_outputs(input string name);
        check(name, {busy, in_ready, ram_write_enable, proc_start, out_valid, out_last, job_done, timeout}, 8'h00);
        check({name, "_bus"}, {ram_write_addr, ram_write_data, ram_read_addr, out_data}, '0);
    endtask

    task automatic preload(input logic [DW-1:0] r0, input logic [DW-1:0] r1);
        result_mem[0] = r0;
        result_mem[1] = r1;
        exp_out.push_back('{data: r0, last: 1'b0});
        exp_out.push_back('{data: r1, last: 1'b1});
    endtask

    task automatic start_job();
        check("idle_before_go", busy, 1'b0);
        proc_start_count = 0;
        done_given = 1'b0;
        go = 1'b1;
        @(posedge clock);
        #1 go = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int addr);
        int budget;
        budget = 50;
        exp_wr.push_back('{addr: AW'(addr), data: w});
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clock);
        while (!in_ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL in_accept_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    // Word i of a job is base*(i+1); gaps inserts one idle cycle between words.
    task automatic feed(input logic [DW-1:0] base, input bit gaps);
        for (int i = 0; i < LC; i++) begin
            if (gaps && i > 0) begin
                @(posedge clock);
                #1;
            end
            send_word(base * DW'(i + 1), i);
        end
        check("in_ready_low_after_last", in_ready, 1'b0);
    endtask

    task automatic wait_job_done(input logic exp_timeout);
        int budget;
        budget = 400;
        @(negedge clock);
        while (!job_done && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL job_done_timeout: job_done stayed 0, expected a pulse");
        end else begin
            check("busy_at_job_done", busy, 1'b0);
            check("timeout_at_job_done", timeout, exp_timeout);
            check("proc_start_pulses", proc_start_count, 1);
            check("out_drained", exp_out.size(), 0);
            check("writes_drained", exp_wr.size(), 0);
`ifdef PURSUIT_JOB_SEQUENCER_TIMEOUT_EN
            if (exp_timeout) check("timeout_latency", cyc - start_cyc, TC);
`endif
            @(negedge clock);
            check("job_done_single", job_done, 1'b0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) result_mem[i] = '0;

        // Reset state.
        #2 resetN = 1'b0;
        repeat (2) @(posedge clock);
        #1 check_quiet_outputs("reset_state");
        resetN = 1'b1;
        @(posedge clock);
        #1;

        // Basic job.
        done_delay = 5;
        preload(32'hA0, 32'hB0);
        start_job();
        feed(32'h11, 1'b0);
        wait_job_done(1'b0);

        // Input gaps.
        preload(32'hC0, 32'hD0);
        start_job();
        feed(32'h03, 1'b1);
        wait_job_done(1'b0);

        // Backpressure: out_ready low for 3 cycles on word 0.
        preload(32'hA0, 32'hB0);
        out_ready = 1'b0;
        start_job();
        feed(32'h11, 1'b0);
        begin
            int budget;
            budget = 100;
            @(negedge clock);
            while (!out_valid && budget > 0) begin
                @(negedge clock);
                budget--;
            end
            check("bp_out_valid_seen", out_valid, 1'b1);
        end
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
        wait_job_done(1'b0);

        // proc_done during KICK and go during WAIT_DONE are ignored.
        done_delay = 6;
        preload(32'h1234_5678, 32'h9ABC_DEF0);
        start_job();
        feed(32'h07, 1'b0);
        proc_done_force = 1'b1;
        @(posedge clock);
        #1 proc_done_force = 1'b0;
        go = 1'b1;
        @(posedge clock);
        #1 go = 1'b0;
        wait_job_done(1'b0);
        repeat (2) @(posedge clock);
        #1 check("no_restart_after_ignored_go", busy, 1'b0);

        // Reset mid-LOAD after 2 words, then a clean job from address 0.
        done_delay = 5;
        start_job();
        send_word(32'h11, 0);
        send_word(32'h22, 1);
        @(negedge clock);
        #1 resetN = 1'b0;
        #1 check_quiet_outputs("reset_mid_load");
        @(posedge clock);
        #1 resetN = 1'b1;
        @(posedge clock);
        #1;
        preload(32'hE0, 32'hF0);
        start_job();
        feed(32'h15, 1'b0);
        wait_job_done(1'b0);

`ifdef PURSUIT_JOB_SEQUENCER_TIMEOUT_EN
        // No proc_done: timeout, job_done, no output; next go clears the flag.
        suppress_done = 1'b1;
        start_job();
        feed(32'h09, 1'b0);
        wait_job_done(1'b1);
        suppress_done = 1'b0;
        preload(32'hA0, 32'hB0);
        start_job();
        check("timeout_cleared_by_go", timeout, 1'b0);
        feed(32'h11, 1'b0);
        wait_job_done(1'b0);
`endif

        repeat (3) @(posedge clock);
        #1 check("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
